// File: rtl/conv_window_reader.sv
// Walks one half of the input pre-data buffer and streams 3x3 stride-1 window taps to the
// PE array. Addresses come from incremental adders. Returned bytes pass through a 2-entry
// skid FIFO so that backpressure never drops or duplicates a tap.
module conv_window_reader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_buf_sel,
  input  logic [DIM_W-1:0]  i_fm_row,
  input  logic [DIM_W-1:0]  i_fm_col,
  input  logic [DIM_W-1:0]  i_fm_n,
  output logic [ADDR_W-1:0] o_conv_addr,
  output logic              o_out_choose,
  input  logic [DATA_W-1:0] i_conv_din,
  output logic [DATA_W-1:0] o_pix,
  output logic              o_pix_vld,
  input  logic              i_pix_rdy,
  output logic              o_win_first,
  output logic              o_win_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic              buf_sel_q;
  logic [DIM_W-1:0]  row_q, col_q, n_q;
  logic [ADDR_W-1:0] s_q, cs_q;
  logic [DIM_W-1:0]  r_q, c_q, ch_q;
  logic [1:0]        ky_q, kx_q;
  logic [ADDR_W-1:0] addr_q, ky_base_q, chan_base_q, pix_base_q, row_base_q;
  logic              infl_q, infl_first_q, infl_last_q;
  logic [DATA_W+1:0] fifo0_q, fifo1_q;  // {first, last, data}; fifo0_q is the head
  logic [1:0]        cnt_q;

  logic              pop, issue, frame_end, zero_dim, tap_first, tap_last;
  logic              last_kx, last_ky, last_ch, last_c, last_r;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] s_calc, cs_calc;
  logic [DATA_W+1:0] push_entry;

  // Issue gating, tap position decode and stride arithmetic
  always_comb begin
    pop       = (cnt_q != 2'd0) && i_pix_rdy;
    // A head leaving this cycle frees its slot, keeping 1 tap/cycle with the PE ready
    occ       = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
    issue     = (state_q == StRun) && (occ < 3'd2);
    last_kx   = (kx_q == 2'd2);
    last_ky   = (ky_q == 2'd2);
    last_ch   = (ch_q == n_q - DIM_W'(1));
    last_c    = (c_q == col_q - DIM_W'(1));
    last_r    = (r_q == row_q - DIM_W'(1));
    tap_first = (ch_q == '0) && (ky_q == 2'd0) && (kx_q == 2'd0);
    tap_last  = last_ch && last_ky && last_kx;
    frame_end = issue && tap_last && last_c && last_r;
    zero_dim  = (row_q == '0) || (col_q == '0) || (n_q == '0);
    s_calc    = ADDR_W'(col_q) + ADDR_W'(2);
    cs_calc   = (ADDR_W'(row_q) + ADDR_W'(2)) * s_calc;
    push_entry = {infl_first_q, infl_last_q, i_conv_din};
  end

  // Next-state logic and the done pulse
  always_comb begin
    state_d = state_q;
    o_done  = 1'b0;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StLoad;
      StLoad:  state_d = zero_dim ? StDrain : StRun;
      StRun:   if (frame_end) state_d = StDrain;
      StDrain: begin
        if ((cnt_q == 2'd0) && !infl_q) begin
          o_done  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register, parameter latch and tap address walker
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      buf_sel_q   <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      n_q         <= '0;
      s_q         <= '0;
      cs_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
      ch_q        <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      addr_q      <= '0;
      ky_base_q   <= '0;
      chan_base_q <= '0;
      pix_base_q  <= '0;
      row_base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && i_start) begin
        buf_sel_q <= i_buf_sel;
        row_q     <= i_fm_row;
        col_q     <= i_fm_col;
        n_q       <= i_fm_n;
      end
      if (state_q == StLoad) begin
        s_q         <= s_calc;
        cs_q        <= cs_calc;
        r_q         <= '0;
        c_q         <= '0;
        ch_q        <= '0;
        ky_q        <= '0;
        kx_q        <= '0;
        addr_q      <= '0;
        ky_base_q   <= '0;
        chan_base_q <= '0;
        pix_base_q  <= '0;
        row_base_q  <= '0;
      end
      if (issue) begin
        if (!last_kx) begin
          kx_q   <= kx_q + 2'd1;
          addr_q <= addr_q + ADDR_W'(1);
        end else begin
          kx_q <= 2'd0;
          if (!last_ky) begin
            ky_q      <= ky_q + 2'd1;
            ky_base_q <= ky_base_q + s_q;
            addr_q    <= ky_base_q + s_q;
          end else begin
            ky_q <= 2'd0;
            if (!last_ch) begin
              ch_q        <= ch_q + DIM_W'(1);
              chan_base_q <= chan_base_q + cs_q;
              ky_base_q   <= chan_base_q + cs_q;
              addr_q      <= chan_base_q + cs_q;
            end else begin
              ch_q <= '0;
              if (!last_c) begin
                c_q         <= c_q + DIM_W'(1);
                pix_base_q  <= pix_base_q + ADDR_W'(1);
                chan_base_q <= pix_base_q + ADDR_W'(1);
                ky_base_q   <= pix_base_q + ADDR_W'(1);
                addr_q      <= pix_base_q + ADDR_W'(1);
              end else if (!last_r) begin
                c_q         <= '0;
                r_q         <= r_q + DIM_W'(1);
                row_base_q  <= row_base_q + s_q;
                pix_base_q  <= row_base_q + s_q;
                chan_base_q <= row_base_q + s_q;
                ky_base_q   <= row_base_q + s_q;
                addr_q      <= row_base_q + s_q;
              end
            end
          end
        end
      end
    end
  end

  // Read-in-flight tracking and 2-entry skid FIFO
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      infl_q       <= 1'b0;
      infl_first_q <= 1'b0;
      infl_last_q  <= 1'b0;
      fifo0_q      <= '0;
      fifo1_q      <= '0;
      cnt_q        <= 2'd0;
    end else begin
      infl_q       <= issue;
      infl_first_q <= issue && tap_first;
      infl_last_q  <= issue && tap_last;
      if (infl_q && pop) begin
        if (cnt_q == 2'd1) begin
          fifo0_q <= push_entry;
        end else begin
          fifo0_q <= fifo1_q;
          fifo1_q <= push_entry;
        end
      end else if (infl_q) begin
        if (cnt_q == 2'd0) fifo0_q <= push_entry;
        else               fifo1_q <= push_entry;
        cnt_q <= cnt_q + 2'd1;
      end else if (pop) begin
        fifo0_q <= fifo1_q;
        cnt_q   <= cnt_q - 2'd1;
      end
    end
  end

  // Output drive from the FIFO head and latched controls
  always_comb begin
    o_conv_addr  = addr_q;
    o_out_choose = buf_sel_q;
    o_busy       = (state_q != StIdle);
    o_pix_vld    = (cnt_q != 2'd0);
    o_pix        = fifo0_q[DATA_W-1:0];
    o_win_first  = o_pix_vld && fifo0_q[DATA_W+1];
    o_win_last   = o_pix_vld && fifo0_q[DATA_W];
  end

endmodule
